// File: rtl/uart_pkg.sv
// Purpose: shared types and constants for the UART TX path (and later the RX path).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

  // Transmit FSM states, in frame order.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  // parity_mode codes; 2'b11 also means no parity.
  localparam int              PAR_W    = 2;
  localparam logic [PAR_W-1:0] PAR_NONE = 2'b00;
  localparam logic [PAR_W-1:0] PAR_EVEN = 2'b01;
  localparam logic [PAR_W-1:0] PAR_ODD  = 2'b10;

  // Smallest usable bit period in clk cycles; smaller baud_div values are clamped.
  localparam int MIN_BAUD_DIV = 2;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Purpose: CPU-side write bus plus serial line/status of the UART transmitter.
// Latency: n/a (signal bundle only).
// Backpressure: writer watches full; writes while full are dropped and flagged by overflow.
// Ports: master = register block (drives baud_div, parity_mode, data_in, we);
//        slave  = uart_tx_fifo (drives full, fifo_count, overflow, data_out, busy).
import uart_pkg::*;

interface uart_tx_fifo_if #(
  parameter int DATA_BITS = 8,
  parameter int DIV_W     = 16,
  parameter int CNT_W     = 5
);
  logic [DIV_W-1:0]     baud_div;
  logic [PAR_W-1:0]     parity_mode;
  logic [DATA_BITS-1:0] data_in;
  logic                 we;
  logic                 full;
  logic [CNT_W-1:0]     fifo_count;
  logic                 overflow;
  logic                 data_out;
  logic                 busy;

  modport master (
    output baud_div, parity_mode, data_in, we,
    input  full, fifo_count, overflow, data_out, busy
  );

  modport slave (
    input  baud_div, parity_mode, data_in, we,
    output full, fifo_count, overflow, data_out, busy
  );
endinterface

// File: rtl/sync_fifo.sv
// Purpose: generic synchronous FIFO with registered storage, full/empty/count flags.
// Latency: a pushed word is visible on rdata the cycle after the push edge.
// Backpressure: push ignored while full, pop ignored while empty; caller gates with the flags.
// Ports: clk/rst_n; push+wdata write side; pop+rdata read side (rdata = head, show-ahead);
//        full, empty, count status.
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];
  assign count = count_q;
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/uart_tx_fifo.sv
// Purpose: UART transmitter (DATA_BITS, 1/2 stop bits, runtime baud divisor) behind a TX FIFO;
//          optional parity bit built only when UART_TX_PARITY_EN is defined.
// Latency: write into an empty FIFO at edge N -> start bit on data_out from edge N+1.
// Backpressure: full high at FIFO_DEPTH entries; a write while full is dropped and overflow pulses.
// Ports: clk, rst_n (async, active low); bus (slave modport of uart_tx_fifo_if) carrying
//        baud_div, parity_mode, data_in, we in and full, fifo_count, overflow, data_out, busy out.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input logic           clk,
  input logic           rst_n,
  uart_tx_fifo_if.slave bus
);
  localparam int               BIT_W   = 4;
  localparam logic [DIV_W-1:0] MIN_DIV = DIV_W'(MIN_BAUD_DIV);

  tx_state_e            state_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DIV_W-1:0]     div_q;
  logic [DIV_W-1:0]     baud_cnt_q;
  logic [BIT_W-1:0]     bit_idx_q;
  logic                 data_out_q;
  logic                 overflow_q;

  logic [DATA_BITS-1:0] fifo_rdata;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [CNT_W-1:0]     fifo_count;
  logic                 bit_done;
  logic                 stop_last;
  logic                 load;
  logic [DIV_W-1:0]     div_clamped;

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (bus.we),
    .wdata (bus.data_in),
    .pop   (load),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign div_clamped = (bus.baud_div < MIN_DIV) ? MIN_DIV : bus.baud_div;
  assign bit_done    = (baud_cnt_q == div_q - DIV_W'(1));
  assign stop_last   = (bit_idx_q == BIT_W'(STOP_BITS - 1));
  // Start a frame from IDLE, or chain straight out of the last stop bit so frames abut.
  assign load = !fifo_empty &&
                ((state_q == IDLE) || ((state_q == STOP) && bit_done && stop_last));

`ifdef UART_TX_PARITY_EN
  logic par_en_q;
  logic par_q;
`else
  logic unused_parity_mode;
  assign unused_parity_mode = ^bus.parity_mode;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      div_q      <= MIN_DIV;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      data_out_q <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_en_q   <= 1'b0;
      par_q      <= 1'b0;
`endif
    end else if (load) begin
      // Divisor and parity mode are captured only here, so a running frame never changes rate.
      state_q    <= START;
      shift_q    <= fifo_rdata;
      div_q      <= div_clamped;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      data_out_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_q   <= (bus.parity_mode == PAR_EVEN) || (bus.parity_mode == PAR_ODD);
      par_q      <= (^fifo_rdata) ^ (bus.parity_mode == PAR_ODD);
`endif
    end else begin
      baud_cnt_q <= bit_done ? '0 : baud_cnt_q + DIV_W'(1);
      case (state_q)
        IDLE: begin
          baud_cnt_q <= '0;
          data_out_q <= 1'b1;
        end
        START: begin
          if (bit_done) begin
            state_q    <= DATA;
            data_out_q <= shift_q[0];
          end
        end
        DATA: begin
          if (bit_done) begin
            if (bit_idx_q == BIT_W'(DATA_BITS - 1)) begin
              bit_idx_q <= '0;
`ifdef UART_TX_PARITY_EN
              if (par_en_q) begin
                state_q    <= PARITY;
                data_out_q <= par_q;
              end else
`endif
              begin
                state_q    <= STOP;
                data_out_q <= 1'b1;
              end
            end else begin
              // shift_q[0] is the bit on the line; the next one is shift_q[1].
              bit_idx_q  <= bit_idx_q + BIT_W'(1);
              data_out_q <= shift_q[1];
              shift_q    <= shift_q >> 1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_done) begin
            state_q    <= STOP;
            data_out_q <= 1'b1;
          end
        end
`endif
        STOP: begin
          data_out_q <= 1'b1;
          if (bit_done) begin
            if (stop_last) begin
              state_q   <= IDLE;
              bit_idx_q <= '0;
            end else begin
              bit_idx_q <= bit_idx_q + BIT_W'(1);
            end
          end
        end
        default: begin
          state_q    <= IDLE;
          data_out_q <= 1'b1;
        end
      endcase
    end
  end

  // Dropped write is reported one cycle later, independent of any same-cycle pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) overflow_q <= 1'b0;
    else        overflow_q <= bus.we && fifo_full;
  end

  assign bus.full       = fifo_full;
  assign bus.fifo_count = fifo_count;
  assign bus.overflow   = overflow_q;
  assign bus.data_out   = data_out_q;
  assign bus.busy       = (state_q != IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Purpose: directed self-checking bench for uart_tx_fifo (8 data bits, 1 stop bit, depth 4).
// Latency: expected serial line is compared every cycle, starting at the write cycle.
// Backpressure: overflow scenario writes into a full FIFO while a frame is in flight.
module tb_uart_tx_fifo;
  localparam int DB    = 8;
  localparam int DIV_W = 16;
  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_fifo_if #(.DATA_BITS(DB), .DIV_W(DIV_W), .CNT_W(CNT_W)) bus();

  uart_tx_fifo #(
    .DATA_BITS (DB),
    .STOP_BITS (1),
    .DIV_W     (DIV_W),
    .FIFO_DEPTH(DEPTH),
    .CNT_W     (CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0] din;
    int         div;
    int         eff_div;
    logic [1:0] pmode;
    bit         pen;
    bit         pbit;
    int         len;
  } vec_t;

  vec_t       vecs [8];
  logic [7:0] tx_q [$];
  bit         exp_q [$];
  int         n_cmp  = 0;
  int         n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Two idle samples lead every sequence: the write cycle and the push-to-pop cycle.
  task automatic start_seq();
    tx_q.delete();
    exp_q.delete();
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b1);
  endtask

  task automatic add_frame(input logic [7:0] d, input int div, input bit pen, input bit pb);
    repeat (div) exp_q.push_back(1'b0);
    for (int b = 0; b < 8; b++) repeat (div) exp_q.push_back(d[b]);
    if (pen) repeat (div) exp_q.push_back(pb);
    repeat (div) exp_q.push_back(1'b1);
  endtask

  // Writes tx_q on consecutive cycles and compares data_out cycle by cycle against exp_q.
  task automatic run(input string name, input int div_a, input int div_b, input int sw,
                     input int exp_len, input int exp_peak, input int exp_ovf);
    int errs = 0;
    int busy_cyc = 0;
    int peak = 0;
    int ovf = 0;
    int full_seen = 0;
    exp_q.push_back(1'b1);
    for (int c = 0; c < exp_q.size(); c++) begin
      bus.baud_div = DIV_W'((c < sw) ? div_a : div_b);
      if (c < tx_q.size()) begin
        bus.we      = 1'b1;
        bus.data_in = tx_q[c];
      end else begin
        bus.we = 1'b0;
      end
      if (bus.data_out !== exp_q[c]) errs++;
      if (bus.busy === 1'b1) busy_cyc++;
      if (int'(bus.fifo_count) > peak) peak = int'(bus.fifo_count);
      if (bus.overflow === 1'b1) ovf++;
      if (bus.full === 1'b1) full_seen = 1;
      @(negedge clk);
    end
    bus.we = 1'b0;
    for (int c = 0; c < 500 && bus.busy !== 1'b0; c++) begin
      busy_cyc++;
      @(negedge clk);
    end
    check({name, " line_bit_errors"}, errs, 0);
    check({name, " frame_cycles"}, busy_cyc - 1, exp_len);
    check({name, " peak_fifo_count"}, peak, exp_peak);
    check({name, " overflow_pulses"}, ovf, exp_ovf);
    check({name, " full_seen"}, full_seen, (exp_peak == DEPTH) ? 1 : 0);
    check({name, " busy_at_end"}, bus.busy, 0);
  endtask

  initial begin
    int bad;
    bus.we          = 1'b0;
    bus.data_in     = '0;
    bus.baud_div    = DIV_W'(4);
    bus.parity_mode = 2'b00;

    //            din    div eff pmode  pen   pbit  len
    vecs[0] = '{8'hA5, 4, 4, 2'b00, 1'b0, 1'b0, 40};
    vecs[1] = '{8'h00, 2, 2, 2'b00, 1'b0, 1'b0, 20};
    vecs[2] = '{8'hFF, 1, 2, 2'b00, 1'b0, 1'b0, 20};
    vecs[3] = '{8'h3C, 0, 2, 2'b00, 1'b0, 1'b0, 20};
`ifdef UART_TX_PARITY_EN
    vecs[4] = '{8'h07, 4, 4, 2'b01, 1'b1, 1'b1, 44};
    vecs[5] = '{8'h07, 4, 4, 2'b10, 1'b1, 1'b0, 44};
`else
    vecs[4] = '{8'h07, 4, 4, 2'b01, 1'b0, 1'b0, 40};
    vecs[5] = '{8'h07, 4, 4, 2'b10, 1'b0, 1'b0, 40};
`endif
    vecs[6] = '{8'h80, 3, 3, 2'b11, 1'b0, 1'b0, 30};
    vecs[7] = '{8'h01, 5, 5, 2'b00, 1'b0, 1'b0, 50};

    // Reset state
    repeat (3) @(negedge clk);
    check("reset data_out", bus.data_out, 1);
    check("reset busy", bus.busy, 0);
    check("reset full", bus.full, 0);
    check("reset fifo_count", bus.fifo_count, 0);
    check("reset overflow", bus.overflow, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single frames from the table
    for (int i = 0; i < 8; i++) begin
      start_seq();
      tx_q.push_back(vecs[i].din);
      add_frame(vecs[i].din, vecs[i].eff_div, vecs[i].pen, vecs[i].pbit);
      bus.parity_mode = vecs[i].pmode;
      run($sformatf("vec%0d", i), vecs[i].div, vecs[i].div, 0, vecs[i].len, 1, 0);
    end
    bus.parity_mode = 2'b00;

    // Back-to-back frames, no idle gap
    start_seq();
    tx_q.push_back(8'h00); tx_q.push_back(8'hFF); tx_q.push_back(8'h55);
    add_frame(8'h00, 4, 0, 0); add_frame(8'hFF, 4, 0, 0); add_frame(8'h55, 4, 0, 0);
    run("b2b", 4, 4, 0, 120, 2, 0);

    // Overflow: first char in flight, then six writes into a depth-4 FIFO
    start_seq();
    tx_q.push_back(8'h11); tx_q.push_back(8'hA1); tx_q.push_back(8'hB2);
    tx_q.push_back(8'hC3); tx_q.push_back(8'hD4); tx_q.push_back(8'hEE); tx_q.push_back(8'hFF);
    add_frame(8'h11, 4, 0, 0); add_frame(8'hA1, 4, 0, 0); add_frame(8'hB2, 4, 0, 0);
    add_frame(8'hC3, 4, 0, 0); add_frame(8'hD4, 4, 0, 0);
    run("overflow", 4, 4, 0, 200, 4, 2);

    // Baud divisor switched 4 -> 8 during frame 1
    start_seq();
    tx_q.push_back(8'h5A); tx_q.push_back(8'h96);
    add_frame(8'h5A, 4, 0, 0); add_frame(8'h96, 8, 0, 0);
    run("baud_change", 4, 8, 10, 120, 1, 0);

    // Reset in the middle of DATA with a second char queued
    bus.baud_div = DIV_W'(4);
    bus.we = 1'b1; bus.data_in = 8'hC3;
    @(negedge clk);
    bus.data_in = 8'h3C;
    @(negedge clk);
    bus.we = 1'b0;
    repeat (10) @(negedge clk);
    check("midframe busy_before_reset", bus.busy, 1);
    check("midframe count_before_reset", bus.fifo_count, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midframe reset data_out", bus.data_out, 1);
    check("midframe reset fifo_count", bus.fifo_count, 0);
    check("midframe reset busy", bus.busy, 0);
    check("midframe reset full", bus.full, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (bus.data_out !== 1'b1 || bus.busy !== 1'b0) bad++;
    end
    check("post_reset residual_activity", bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised UART transmitter, the next generation of the team's fixed-format 8N1 TX block. It adds a configurable character width, 1 or 2 stop bits, a runtime baud divisor and an internal TX FIFO. Frames go back-to-back with no idle gap while the FIFO holds data. It sits between the CPU's MMIO UART register and the board TX pin.

Parameters:
- DATA_BITS, 8, character width; legal 5..9.
- STOP_BITS, 1, number of stop bits; 1 or 2.
- DIV_W, 16, width of baud_div.
- FIFO_DEPTH, 16, TX FIFO entries; power of two, >= 2.
- CNT_W, $clog2(FIFO_DEPTH)+1, width of fifo_count.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset: rst_n, asynchronous, active-low; clock clk
- baud_div  in  DIV_W  clk cycles per bit; values <2 are treated as 2
- parity_mode  in  2  00 none, 01 even, 10 odd, 11 none (see Optional Feature)
- data_in  in  DATA_BITS  character to send
- we  in  1  write strobe; one character per high cycle
- full  out  1  FIFO holds FIFO_DEPTH entries
- fifo_count  out  CNT_W  entries waiting, excluding the character in flight
- overflow  out  1  one-cycle pulse: a write was dropped
- data_out  out  1  serial TX line, idle high
- busy  out  1  high when state != IDLE or fifo_count != 0

Behaviour:
- Reset (asynchronous, any time, including mid-frame): data_out=1, busy=0, full=0, fifo_count=0, overflow=0. FIFO is emptied, FSM goes to IDLE, counters clear. A partial frame is abandoned.
- FIFO write:
  - we && !full pushes data_in at the edge; fifo_count increments.
  - we && full drops the data and pulses overflow on the next cycle. This holds even if a pop happens in the same cycle.
  - Simultaneous push and pop with non-full leaves fifo_count unchanged.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: if fifo_count != 0, pop into the shift register, latch baud_div (clamped) into div_q, go to START. data_out goes low from that edge. Latency: we sampled at edge N into an empty FIFO, and data_out falls at edge N+1.
  - Every bit is held for exactly div_q cycles. The bit counter runs 0..div_q-1.
  - START (0) -> DATA: sends DATA_BITS bits, LSB first.
  - DATA -> PARITY if parity is active, otherwise -> STOP.
  - STOP: line is 1 for STOP_BITS*div_q cycles.
  - At the end of STOP: if the FIFO is non-empty, pop, re-latch baud_div and go straight to START (no idle cycle). Otherwise go to IDLE.
- baud_div changes take effect only at the next frame start. A frame in progress is never stretched.
- Frame length in cycles = div_q*(1+DATA_BITS+P+STOP_BITS), where P=1 if parity is active, else 0.
- Parity bit: even = XOR of data bits; odd = its inverse. parity_mode is sampled at the frame start together with baud_div.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined: the PARITY state and parity logic are built, and parity_mode selects none, even or odd as above.
- Not defined: the PARITY state is not generated, parity_mode is ignored (port kept, unused), and frames are always no-parity.

Decomposition:
- Package uart_pkg holds:
  - FSM state encoding (IDLE..STOP)
  - parity_mode codes (PAR_NONE, PAR_EVEN, PAR_ODD)
  - MIN_BAUD_DIV=2
- One sub-module, sync_fifo: parametrised DEPTH/WIDTH, registered storage, outputs full, empty and count. It is reused later by the RX path.
- The FSM, shift register and baud counter stay in uart_tx_fifo.

Test Plan:
- Single frame: baud_div=4, 8N1, write 0xA5 -> data_out low at the next edge, then bits 1,0,1,0,0,1,0,1 for 4 cycles each, then high; 40 cycles total; busy falls after the stop bit.
- Back-to-back: write 0x00, 0xFF, 0x55 on three consecutive cycles -> three 40-cycle frames with no idle gap; fifo_count peaks at 2 (0x00 popped before 0x55 is written, and 0x00 is not counted once in flight).
- Overflow: FIFO_DEPTH=4, FSM stalled mid-frame, 6 writes -> 4 accepted, full=1, two overflow pulses; the dropped values are never transmitted.
- Baud change mid-frame: baud_div switches 4->8 during frame 1 -> frame 1 stays 40 cycles and frame 2 is 80 cycles.
- Parity (macro defined): parity_mode=01, data 0x07 -> parity bit 1; parity_mode=10 -> parity bit 0; frame is 44 cycles at baud_div=4.
- Reset mid-frame: assert rst_n low during DATA -> data_out=1, fifo_count=0 and busy=0 immediately; no residual frame after release.
